// File: rtl/shift_sequencer.sv
// Single-clock run-time controller for a 4-bit shift-left display register.
// A prescaler paces shifts; an IDLE/RUN/PAUSE FSM handles load, pause, single-step and counted runs.
module shift_sequencer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             step,
  input  logic [3:0]       load_val,
  input  logic             rotate,
  input  logic             ser_in,
  input  logic [CNT_W-1:0] period,
  input  logic [3:0]       shift_cnt,
  output logic [3:0]       q,
  output logic             tick,
  output logic             busy,
  output logic             paused,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [3:0]       remaining_q, remaining_d;
  logic             cont_q, cont_d;
  logic [3:0]       q_q, q_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             load;
  logic             do_shift;
  logic             fill_bit;

  assign fill_bit = rotate ? q_q[3] : ser_in;

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    remaining_d = remaining_q;
    cont_d      = cont_q;
    q_d         = q_q;
    tick_d      = 1'b0;
    done_d      = 1'b0;
    load        = 1'b0;
    do_shift    = 1'b0;

    // start always wins; pause beats any shift due in the same cycle
    case (state_q)
      IDLE: begin
        if (start) load = 1'b1;
      end
      RUN: begin
        if (start) begin
          load = 1'b1;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (counter_q >= period) begin
          do_shift  = 1'b1;
          counter_d = '0;
        end else begin
          counter_d = counter_q + CNT_W'(1);
        end
      end
      PAUSE: begin
        if (start) begin
          load = 1'b1;
        end else if (pause) begin
          state_d = RUN;
        end else if (step) begin
          do_shift = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      q_d         = load_val;
      remaining_d = shift_cnt;
      cont_d      = (shift_cnt == 4'd0);
      counter_d   = '0;
      state_d     = RUN;
    end

    if (do_shift) begin
      q_d    = {q_q[2:0], fill_bit};
      tick_d = 1'b1;
      // remaining is meaningless in continuous mode, so leave it untouched
      if (!cont_q) begin
        remaining_d = remaining_q - 4'd1;
        if (remaining_q == 4'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      remaining_q <= '0;
      cont_q      <= 1'b0;
      q_q         <= '0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      remaining_q <= remaining_d;
      cont_q      <= cont_d;
      q_q         <= q_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
    end
  end

  assign q      = q_q;
  assign tick   = tick_q;
  assign done   = done_q;
  assign busy   = (state_q != IDLE);
  assign paused = (state_q == PAUSE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: stimulus pushes expected (edge, q, done) per shift,
// a negedge monitor pops and compares whenever tick is high.
`timescale 1ns/1ps
module tb_shift_sequencer;

  localparam int CNT_W = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, pause, step, rotate, ser_in;
  logic [3:0]       load_val, shift_cnt;
  logic [CNT_W-1:0] period;
  logic [3:0]       q;
  logic             tick, busy, paused, done;

  typedef struct {
    int         cyc;
    logic [3:0] q;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  shift_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .step(step),
    .load_val(load_val), .rotate(rotate), .ser_in(ser_in), .period(period),
    .shift_cnt(shift_cnt), .q(q), .tick(tick), .busy(busy), .paused(paused),
    .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic push(input int c, input logic [3:0] qv, input logic dv);
    exp_t e;
    e.cyc  = c;
    e.q    = qv;
    e.done = dv;
    sb.push_back(e);
  endtask

  // Call just after a negedge; returns at the negedge following the start edge.
  task automatic pulse_start(output int se);
    se    = cyc + 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: every tick must match the next expected shift, including its edge number.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (tick === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_tick cyc=%0d actual tick=1 q=%b required tick=0", cyc, q);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("tick_edge", cyc, e.cyc);
          chk("shift_q", q, e.q);
          chk("shift_done", done, e.done);
          $display("shift cyc=%0d q=%b done=%b (exp cyc=%0d q=%b done=%b)",
                   cyc, q, done, e.cyc, e.q, e.done);
        end
      end else if (done === 1'b1) begin
        checks++;
        failures++;
        $display("FAIL done_without_tick cyc=%0d actual done=1 required done=0", cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int se, s2, r, e;
    rst = 1'b0; start = 1'b0; pause = 1'b0; step = 1'b0;
    rotate = 1'b1; ser_in = 1'b0; load_val = 4'd0; shift_cnt = 4'd0; period = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_q", q, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_paused", paused, 1'b0);
    chk("rst_tick", tick, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_release", busy, 1'b0);

    // Counted rotate: period 3, five shifts, done on the fifth
    period = 24'd3; load_val = 4'b0001; rotate = 1'b1; shift_cnt = 4'd5;
    pulse_start(se);
    push(se + 4, 4'b0010, 1'b0);
    push(se + 8, 4'b0100, 1'b0);
    push(se + 12, 4'b1000, 1'b0);
    push(se + 16, 4'b0001, 1'b0);
    push(se + 20, 4'b0010, 1'b1);
    chk("cnt_loaded_q", q, 4'b0001);
    chk("cnt_busy", busy, 1'b1);
    chk("cnt_paused", paused, 1'b0);
    repeat (20) @(negedge clk);
    chk("cnt_busy_after_done", busy, 1'b0);
    wait_drain("cnt_drain");

    // Continuous rotate at period 0: a shift every edge
    period = '0; load_val = 4'b1000; shift_cnt = 4'd0;
    pulse_start(se);
    push(se + 1, 4'b0001, 1'b0);
    push(se + 2, 4'b0010, 1'b0);
    push(se + 3, 4'b0100, 1'b0);
    push(se + 4, 4'b1000, 1'b0);
    repeat (4) @(negedge clk);
    chk("cont_busy", busy, 1'b1);

    // Serial fill; its start lands while the continuous run is live, so no shift that edge
    rotate = 1'b0; ser_in = 1'b1; load_val = 4'b0000; period = 24'd1; shift_cnt = 4'd4;
    pulse_start(se);
    push(se + 2, 4'b0001, 1'b0);
    push(se + 4, 4'b0011, 1'b0);
    push(se + 6, 4'b0111, 1'b0);
    push(se + 8, 4'b1111, 1'b1);
    chk("ser_reload_q", q, 4'b0000);
    repeat (8) @(negedge clk);
    chk("ser_busy_after_done", busy, 1'b0);
    wait_drain("ser_drain");

    // Pause / step / resume
    rotate = 1'b1; load_val = 4'b0001; period = 24'd3; shift_cnt = 4'd6;
    pulse_start(se);
    push(se + 4, 4'b0010, 1'b0);
    push(se + 8, 4'b0100, 1'b0);
    repeat (8) @(negedge clk);
    pulse_pause();
    chk("ps_paused", paused, 1'b1);
    chk("ps_busy", busy, 1'b1);
    repeat (20) @(negedge clk);
    chk("ps_q_frozen", q, 4'b0100);
    chk("ps_still_paused", paused, 1'b1);
    e = cyc + 1;
    push(e, 4'b1000, 1'b0);
    step = 1'b1;
    @(negedge clk);
    e = cyc + 1;
    push(e, 4'b0001, 1'b0);
    @(negedge clk);
    step = 1'b0;
    chk("ps_paused_after_steps", paused, 1'b1);
    r = cyc + 1;
    push(r + 4, 4'b0010, 1'b0);
    push(r + 8, 4'b0100, 1'b1);
    pulse_pause();
    chk("ps_resumed", paused, 1'b0);
    repeat (8) @(negedge clk);
    chk("ps_busy_after_done", busy, 1'b0);
    wait_drain("ps_drain");

    // Collisions: start+pause reloads; pause on the shift cycle defers that shift
    load_val = 4'b0001; period = 24'd3; shift_cnt = 4'd3;
    pulse_start(se);
    push(se + 4, 4'b0010, 1'b0);
    repeat (5) @(negedge clk);
    load_val = 4'b0100;
    s2 = cyc + 1;
    start = 1'b1; pause = 1'b1;
    @(negedge clk);
    start = 1'b0; pause = 1'b0;
    chk("col_reload_q", q, 4'b0100);
    chk("col_reload_busy", busy, 1'b1);
    chk("col_reload_paused", paused, 1'b0);
    repeat (3) @(negedge clk);
    chk("col_at_counter_eq", cyc, s2 + 3);
    pulse_pause();
    chk("col_pause_paused", paused, 1'b1);
    chk("col_pause_q", q, 4'b0100);
    chk("col_pause_tick", tick, 1'b0);
    repeat (3) @(negedge clk);
    r = cyc + 1;
    push(r + 1, 4'b1000, 1'b0);
    push(r + 5, 4'b0001, 1'b0);
    push(r + 9, 4'b0010, 1'b1);
    pulse_pause();
    repeat (9) @(negedge clk);
    chk("col_busy_after_done", busy, 1'b0);
    wait_drain("col_drain");

    // Asynchronous reset mid-run at q=0100, tick still high
    period = 24'd3; load_val = 4'b0001; rotate = 1'b1; shift_cnt = 4'd0;
    pulse_start(se);
    push(se + 4, 4'b0010, 1'b0);
    push(se + 8, 4'b0100, 1'b0);
    repeat (8) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_q", q, 4'd0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_tick", tick, 1'b0);
    chk("arst_paused", paused, 1'b0);
    chk("arst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("arst_stay_idle", busy, 1'b0);
    chk("arst_stay_q", q, 4'd0);
    chk("arst_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
